// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed, checksummed byte
// stream, packs it into little-endian 32-bit words and writes them to imem.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 400,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_cnt;
  logic [1:0]       byte_cnt;
  logic [7:0]       chk;
  logic             xfer;
  logic [LEN_W-1:0] len_full;
  logic [31:0]      len_bytes;
  logic [7:0]       chk_final;

  assign xfer      = in_valid & in_ready;
  assign len_full  = {in_data, len[7:0]};
  assign len_bytes = 32'({len_full, 2'b00});
  assign chk_final = chk + in_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) state_n = LEN0;
      LEN0:  if (xfer) state_n = LEN1;
      LEN1: begin
        if (xfer) begin
          if (len_bytes > MEM_BYTES)  state_n = ERROR;
          else if (len_full == '0)    state_n = CHECK;
          else                        state_n = DATA;
        end
      end
      DATA:  if (xfer && byte_cnt == 2'd3) state_n = WRITE;
      WRITE: state_n = (word_cnt + 16'd1 == len) ? CHECK : DATA;
      CHECK: if (xfer) state_n = (chk_final == 8'd0) ? DONE : ERROR;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs follow the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      chk      <= '0;
    end else begin
      in_ready <= (state_n == LEN0) || (state_n == LEN1) ||
                  (state_n == DATA) || (state_n == CHECK);
      wr_en    <= (state_n == WRITE);
      cpu_hold <= !((state_n == IDLE) || (state_n == DONE));
      done     <= (state_n == DONE);
      error    <= (state_n == ERROR);
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            chk      <= '0;
          end
        end
        LEN0: if (xfer) len[7:0]  <= in_data;
        LEN1: if (xfer) len[15:8] <= in_data;
        DATA: begin
          if (xfer) begin
            wr_data[{byte_cnt, 3'b000} +: 8] <= in_data;
            chk      <= chk + in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) wr_addr <= ADDR_W'({word_cnt, 2'b00});
          end
        end
        WRITE: word_cnt <= word_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames with random
// handshake gaps, compared against a frame-level reference model.
module tb_imem_loader;

  localparam int unsigned MEM_BYTES = 400;
  localparam int unsigned ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  frame_q[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Presents frame_q bytes; a byte advances only when the loader is ready
  task automatic feed(input int gap_pct);
    int i = 0;
    int cyc = 0;
    while (i < frame_q.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = frame_q[i];
        if (in_ready) i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("feed_progress", 32'(i), 32'(frame_q.size()));
  endtask

  // Frame of n words with good or corrupted checksum; oversize frames stop after the length
  task automatic build(input int n, input bit good);
    logic [7:0] sum = 8'd0;
    frame_q = {};
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (4 * n <= int'(MEM_BYTES)) begin
      for (int k = 0; k < 4 * n; k++) begin
        logic [7:0] b = 8'($urandom);
        frame_q.push_back(b);
        sum = sum + b;
      end
      frame_q.push_back(good ? 8'(0 - sum) : 8'(8'(0 - sum) + 8'($urandom_range(1, 255))));
    end
  endtask

  // Reference model: derives expected writes and final flags from the frame itself
  task automatic run_and_check(input string tag, input int gap_pct);
    int n;
    bit over;
    int sum;
    bit exp_done;
    got_addr = {};
    got_data = {};
    pulse_start();
    check({tag, "_hold_on_start"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    feed(gap_pct);
    repeat (2) @(negedge clk);
    n = int'(frame_q[0]) + 256 * int'(frame_q[1]);
    over = (4 * n > int'(MEM_BYTES));
    sum = 0;
    if (!over) for (int k = 2; k < 2 + 4 * n + 1; k++) sum += int'(frame_q[k]);
    exp_done = !over && (sum % 256 == 0);
    check({tag, "_nwrites"}, 32'(got_addr.size()), over ? 32'd0 : 32'(n));
    if (!over && got_addr.size() == n) begin
      for (int k = 0; k < n; k++) begin
        check({tag, "_addr"}, got_addr[k], 32'(4 * k));
        check({tag, "_data"}, got_data[k], {frame_q[2+4*k+3], frame_q[2+4*k+2],
                                            frame_q[2+4*k+1], frame_q[2+4*k]});
      end
    end
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    frame_q = {8'h01, 8'h00, 8'h93, 8'h00, 8'h80, 8'h00, 8'hED};
    run_and_check("t1", 0);
    if (got_data.size() > 0) check("t1_word", got_data[0], 32'h0080_0093);

    frame_q = {8'h02, 8'h00, 8'h93, 8'h00, 8'h80, 8'h00, 8'h23, 8'h20, 8'h10, 8'h00, 8'h9A};
    run_and_check("t2", 0);
    if (got_data.size() > 1) check("t2_word1", got_data[1], 32'h0010_2023);
    run_and_check("t2_gaps", 50);

    frame_q = {8'h65, 8'h00};
    run_and_check("t3_over", 20);

    frame_q = {8'h01, 8'h00, 8'h93, 8'h00, 8'h80, 8'h00, 8'hEE};
    run_and_check("t4_badchk", 0);

    frame_q = {8'h00, 8'h00, 8'h00};
    run_and_check("t5_zero", 0);
    build(1, 1'b1);
    run_and_check("t5_restart", 30);

    build(100, 1'b1);
    run_and_check("full_mem", 0);

    for (int r = 0; r < 6; r++) begin
      build(int'($urandom_range(1, 6)), ($urandom_range(3) != 0));
      run_and_check("rand", int'($urandom_range(0, 60)));
    end
    build(int'($urandom_range(101, 600)), 1'b1);
    run_and_check("rand_over", 10);

    // Reset mid-word: two data bytes in, nothing written, everything back to zero
    got_addr = {};
    frame_q = {8'h01, 8'h00, 8'h93, 8'h00};
    pulse_start();
    feed(0);
    rst = 1'b1;
    #1;
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t6_wr_data", wr_data, 32'd0);
    check("t6_done_err", 32'({done, error, wr_en}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_nwrites", 32'(got_addr.size()), 32'd0);
    frame_q = {8'h01, 8'h00, 8'h93, 8'h00, 8'h80, 8'h00, 8'hED};
    run_and_check("t6_after", 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
